// File: rtl/madgwick_wb_stream.sv
// Wishbone front end for the attitude filter core: staging registers, sample
// FIFO, valid/ready streaming into the core, latched quaternion results,
// completed-update counter and W1C interrupt status.
module madgwick_wb_stream #(
  parameter int ACC_WIDTH  = 16,
  parameter int GYRO_WIDTH = 16,
  parameter int Q_WIDTH    = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [5:0]                           adr_i,
  input  logic [31:0]                          dat_i,
  output logic [31:0]                          dat_o,
  input  logic                                 we_i,
  input  logic                                 stb_i,
  input  logic                                 cyc_i,
  output logic                                 ack_o,
  output logic                                 inta_o,
  output logic                                 core_rst_n,
  output logic                                 core_valid_in,
  input  logic                                 core_ready_in,
  output logic [3*ACC_WIDTH+3*GYRO_WIDTH-1:0]  core_sample,
  input  logic                                 core_valid_out,
  output logic                                 core_ready_out,
  input  logic [4*Q_WIDTH-1:0]                 core_q
);

  localparam int SW = 3*ACC_WIDTH + 3*GYRO_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Word indices (byte address >> 2)
  localparam logic [3:0] R_CTRL   = 4'd0;
  localparam logic [3:0] R_STATUS = 4'd1;
  localparam logic [3:0] R_IRQ    = 4'd2;
  localparam logic [3:0] R_AX     = 4'd3;
  localparam logic [3:0] R_AY     = 4'd4;
  localparam logic [3:0] R_AZ     = 4'd5;
  localparam logic [3:0] R_WX     = 4'd6;
  localparam logic [3:0] R_WY     = 4'd7;
  localparam logic [3:0] R_WZ     = 4'd8;
  localparam logic [3:0] R_PUSH   = 4'd9;
  localparam logic [3:0] R_QW     = 4'd10;
  localparam logic [3:0] R_QX     = 4'd11;
  localparam logic [3:0] R_QY     = 4'd12;
  localparam logic [3:0] R_QZ     = 4'd13;
  localparam logic [3:0] R_COUNT  = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, state_nx;

  logic [3:0] idx;
  logic       valid_wb, acc, wr, rd;
  logic       wr_ctrl, wr_irq, push_req;
  logic [31:0] rdata;

  logic en_q, cont_q, ien_done, ien_ovf;
  logic en_next, flush, start_pend;

  logic [SW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty, pop, push_ok, ovf_evt, res_fire;
  logic [SW-1:0] sample_hold;

  logic [2:0][ACC_WIDTH-1:0]  stg_a;
  logic [2:0][GYRO_WIDTH-1:0] stg_g;
  logic [3:0][Q_WIDTH-1:0]    q_r;
  logic [CNT_WIDTH-1:0]       count;
  logic                       irq_done, irq_ovf;

  // Byte-lane bits and upper write-data bits are not decoded
  logic unused_bits;
  assign unused_bits = ^{adr_i[1:0], dat_i};

  // Bus decode: an access is taken in the cycle its ack is being registered
  assign idx      = adr_i[5:2];
  assign valid_wb = cyc_i & stb_i;
  assign acc      = valid_wb & ~ack_o;
  assign wr       = acc & we_i;
  assign rd       = acc & ~we_i;
  assign wr_ctrl  = wr & (idx == R_CTRL);
  assign wr_irq   = wr & (idx == R_IRQ);
  assign push_req = wr & (idx == R_PUSH);

  // Enable as it will be next cycle; disabling flushes and resets everything
  assign en_next = wr_ctrl ? dat_i[0] : en_q;
  assign flush   = (wr_ctrl & dat_i[5]) | ~en_next;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push_req & (~full | pop);
  assign ovf_evt = push_req & full & ~pop;

  assign core_sample = sample_hold;
  assign inta_o      = (irq_done & ien_done) | (irq_ovf & ien_ovf);

  // Wishbone ack (one wait state) and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= acc;
      if (rd) dat_o <= rdata;
    end
  end

  // Read mux, unmapped words read 0
  always_comb begin
    rdata = '0;
    case (idx)
      R_CTRL:   rdata = {26'd0, 1'b0, ien_ovf, ien_done, 1'b0, cont_q, en_q};
      R_STATUS: rdata = {16'd0, 8'(level), 5'd0, full, empty, state != S_IDLE};
      R_IRQ:    rdata = {30'd0, irq_ovf, irq_done};
      R_AX:     rdata = 32'(stg_a[0]);
      R_AY:     rdata = 32'(stg_a[1]);
      R_AZ:     rdata = 32'(stg_a[2]);
      R_WX:     rdata = 32'(stg_g[0]);
      R_WY:     rdata = 32'(stg_g[1]);
      R_WZ:     rdata = 32'(stg_g[2]);
      R_QW:     rdata = 32'(q_r[0]);
      R_QX:     rdata = 32'(q_r[1]);
      R_QY:     rdata = 32'(q_r[2]);
      R_QZ:     rdata = 32'(q_r[3]);
      R_COUNT:  rdata = 32'(count);
      default:  rdata = '0;
    endcase
  end

  // CTRL bits, core reset follows the enable value being written
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      cont_q     <= 1'b0;
      ien_done   <= 1'b0;
      ien_ovf    <= 1'b0;
      core_rst_n <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q     <= dat_i[0];
        cont_q   <= dat_i[1];
        ien_done <= dat_i[3];
        ien_ovf  <= dat_i[4];
      end
      core_rst_n <= en_next;
      start_pend <= en_next & ((wr_ctrl & dat_i[2]) | (start_pend & ~pop));
    end
  end

  // Staging registers for the next sample to push
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_a <= '0;
      stg_g <= '0;
    end else if (wr) begin
      case (idx)
        R_AX:    stg_a[0] <= dat_i[ACC_WIDTH-1:0];
        R_AY:    stg_a[1] <= dat_i[ACC_WIDTH-1:0];
        R_AZ:    stg_a[2] <= dat_i[ACC_WIDTH-1:0];
        R_WX:    stg_g[0] <= dat_i[GYRO_WIDTH-1:0];
        R_WY:    stg_g[1] <= dat_i[GYRO_WIDTH-1:0];
        R_WZ:    stg_g[2] <= dat_i[GYRO_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // FIFO storage; packed staging order gives {w_z..w_x, a_z..a_x}
  always_ff @(posedge clk) begin
    if (push_ok & ~flush) mem[wr_ptr] <= {stg_g, stg_a};
  end

  // FIFO pointers and level; a flush overrides any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
    end
  end

  // Streaming FSM next state; disable forces IDLE and drops any result
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    res_fire = 1'b0;
    case (state)
      S_IDLE:
        if (en_q && !flush && !empty && (cont_q || start_pend)) begin
          pop      = 1'b1;
          state_nx = S_ISSUE;
        end
      S_ISSUE:
        if (core_valid_in && core_ready_in) state_nx = S_WAIT;
      S_WAIT:
        if (core_valid_out && core_ready_out) begin
          res_fire = 1'b1;
          state_nx = S_IDLE;
        end
      default: state_nx = S_IDLE;
    endcase
    if (!en_next) begin
      state_nx = S_IDLE;
      pop      = 1'b0;
      res_fire = 1'b0;
    end
  end

  // State register with registered handshake decodes
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      core_valid_in  <= 1'b0;
      core_ready_out <= 1'b0;
    end else begin
      state          <= state_nx;
      core_valid_in  <= (state_nx == S_ISSUE);
      core_ready_out <= (state_nx == S_WAIT);
    end
  end

  // Head sample held stable for the whole ISSUE phase
  always_ff @(posedge clk) begin
    if (rst)      sample_hold <= '0;
    else if (pop) sample_hold <= mem[rd_ptr];
  end

  // Result capture and update counter
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      count <= '0;
    end else if (res_fire) begin
      q_r   <= core_q;
      count <= count + CNT_WIDTH'(1);
    end
  end

  // Interrupt status: hardware set beats a same-cycle W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_done <= 1'b0;
      irq_ovf  <= 1'b0;
    end else begin
      irq_done <= res_fire | (irq_done & ~(wr_irq & dat_i[0]));
      irq_ovf  <= ovf_evt  | (irq_ovf  & ~(wr_irq & dat_i[1]));
    end
  end

endmodule
